// File: rtl/uart_opponent_rx.sv
// uart_opponent_rx
// Receives opponent position packets over a UART line (16x oversampling) and
// presents the decoded X/Y position and heading as registered values that only
// ever change together, when a whole packet has been accepted.
//
// Packet: A5, X[7:0], Y[7:0], {X[9:8], Y[9:8], dir[1:0], 2'b00}
//         (+ XOR of bytes 1..3 when UART_CHECKSUM_EN is defined).
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   rx            serial input, idle high, asynchronous to clk
//   xpos_op       opponent X position (10 bits)
//   ypos_op       opponent Y position (10 bits)
//   direction_op  opponent heading (0 up, 1 down, 2 left, 3 right)
//   frame_valid   one-cycle pulse on every committed packet
//   err_count     saturating count of framing, timeout and checksum errors
//
// Optional feature macro: UART_CHECKSUM_EN (adds the checksum byte and CHK state).

`timescale 1ns/1ps

module uart_opponent_rx #(
  parameter int unsigned CLK_FREQ     = 65_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned X_RST        = 300,
  parameter int unsigned Y_RST        = 2,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [9:0] xpos_op,
  output logic [9:0] ypos_op,
  output logic [1:0] direction_op,
  output logic       frame_valid,
  output logic [7:0] err_count
);

  localparam int unsigned DIV_RAW  = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W    = $clog2(DIV + 1);
  localparam int unsigned TO_TICKS = 16 * TIMEOUT_BITS;
  localparam int unsigned TO_W     = $clog2(TO_TICKS + 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {
    PsHunt,
    PsXlo,
    PsYlo,
`ifdef UART_CHECKSUM_EN
    PsHi,
    PsChk
`else
    PsHi
`endif
  } ps_state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser; rx_prev_q is only used for falling-edge detection.
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Oversample tick generator. Restarted on a start edge so the 8-tick
  // mid-bit sample point is measured from the edge itself.
  // ---------------------------------------------------------------------------
  rx_state_e        rx_st_q, rx_st_d;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             start_det;

  assign tick      = (div_q == DIV_W'(DIV - 1));
  assign start_det = (rx_st_q == RxIdle) && rx_prev_q && !rx_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (start_det || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Byte receiver FSM
  // ---------------------------------------------------------------------------
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_ok;
  logic       frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q    <= RxIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      rx_st_q    <= rx_st_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_ok    = 1'b0;
    frame_err  = 1'b0;
    case (rx_st_q)
      RxIdle: begin
        if (start_det) begin
          rx_st_d    = RxStart;
          tick_cnt_d = '0;
        end
      end
      RxStart: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // A high line at mid start bit is a glitch: drop it silently.
            rx_st_d    = rx_sync_q ? RxIdle : RxData;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      RxData: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync_q, shift_q[7:1]};  // LSB first
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_st_d = RxStop;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      RxStop: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            rx_st_d    = RxIdle;
            byte_ok    = rx_sync_q;
            frame_err  = !rx_sync_q;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: rx_st_d = RxIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet parser
  // ---------------------------------------------------------------------------
  ps_state_e       ps_q, ps_d;
  logic [7:0]      xlo_q, xlo_d;
  logic [7:0]      ylo_q, ylo_d;
`ifdef UART_CHECKSUM_EN
  logic [7:0]      hi_q, hi_d;
`endif
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:2]      hi_sel;
  logic            timeout;
  logic            commit;
  logic            err_inc;
  logic [9:0]      xpos_q, ypos_q;
  logic [1:0]      dir_q;
  logic            fv_q;
  logic [7:0]      err_q;

  always_comb begin
    ps_d    = ps_q;
    xlo_d   = xlo_q;
    ylo_d   = ylo_q;
`ifdef UART_CHECKSUM_EN
    hi_d    = hi_q;
    hi_sel  = hi_q[7:2];
`else
    hi_sel  = shift_q[7:2];
`endif
    commit  = 1'b0;
    err_inc = 1'b0;
    timeout = (ps_q != PsHunt) && (to_cnt_q >= TO_W'(TO_TICKS));

    // Inter-byte gap counter: runs only while a packet is in progress.
    if (ps_q == PsHunt || byte_ok) begin
      to_cnt_d = '0;
    end else if (tick && !timeout) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    // Framing error wins over timeout; either costs exactly one count.
    if (frame_err) begin
      ps_d    = PsHunt;
      err_inc = 1'b1;
    end else if (byte_ok) begin
      case (ps_q)
        PsHunt: if (shift_q == 8'hA5) ps_d = PsXlo;
        PsXlo: begin
          xlo_d = shift_q;
          ps_d  = PsYlo;
        end
        PsYlo: begin
          ylo_d = shift_q;
          ps_d  = PsHi;
        end
`ifdef UART_CHECKSUM_EN
        PsHi: begin
          hi_d = shift_q;
          ps_d = PsChk;
        end
        PsChk: begin
          ps_d = PsHunt;
          if (shift_q == (xlo_q ^ ylo_q ^ hi_q)) begin
            commit = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
`else
        PsHi: begin
          ps_d   = PsHunt;
          commit = 1'b1;
        end
`endif
        default: ps_d = PsHunt;
      endcase
    end else if (timeout) begin
      ps_d    = PsHunt;
      err_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q     <= PsHunt;
      xlo_q    <= '0;
      ylo_q    <= '0;
`ifdef UART_CHECKSUM_EN
      hi_q     <= '0;
`endif
      to_cnt_q <= '0;
      xpos_q   <= 10'(X_RST);
      ypos_q   <= 10'(Y_RST);
      dir_q    <= '0;
      fv_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      ps_q     <= ps_d;
      xlo_q    <= xlo_d;
      ylo_q    <= ylo_d;
`ifdef UART_CHECKSUM_EN
      hi_q     <= hi_d;
`endif
      to_cnt_q <= to_cnt_d;
      fv_q     <= commit;
      // All three outputs load together so they never mix two packets.
      if (commit) begin
        xpos_q <= {hi_sel[7:6], xlo_q};
        ypos_q <= {hi_sel[5:4], ylo_q};
        dir_q  <= hi_sel[3:2];
      end
      if (err_inc && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign xpos_op      = xpos_q;
  assign ypos_op      = ypos_q;
  assign direction_op = dir_q;
  assign frame_valid  = fv_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_uart_opponent_rx.sv
// Testbench for uart_opponent_rx: directed UART byte stimulus, a packet-level
// reference model and a per-cycle output comparison.

`timescale 1ns/1ps

module tb_uart_opponent_rx;

  // Small clock-to-baud ratio keeps the run short: DIV = 4, 64 clocks per bit.
  localparam int unsigned CLK_FREQ     = 7_372_800;
  localparam int unsigned BAUD         = 115_200;
  localparam int unsigned TIMEOUT_BITS = 20;
  localparam int unsigned BIT_CLKS     = (CLK_FREQ / (BAUD * 16)) * 16;
`ifdef UART_CHECKSUM_EN
  localparam int unsigned PKT_LEN = 5;
`else
  localparam int unsigned PKT_LEN = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [9:0] xpos_op, ypos_op;
  logic [1:0] direction_op;
  logic       frame_valid;
  logic [7:0] err_count;

  uart_opponent_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .X_RST       (300),
    .Y_RST       (2),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .xpos_op     (xpos_op),
    .ypos_op     (ypos_op),
    .direction_op(direction_op),
    .frame_valid (frame_valid),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_x, m_y, m_dir, m_err, m_commits;
  logic [7:0] m_buf[$];

  // Compare-side state
  bit chk_en   = 1'b0;
  bit settle   = 1'b0;  // outputs allowed to change during this window
  bit fv_prev  = 1'b0;
  int fv_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_x = 300;
    m_y = 2;
    m_dir = 0;
    m_err = 0;
    m_buf.delete();
  endfunction

  function automatic void model_err();
    if (m_err < 255) m_err++;
    m_buf.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    bit ok;
    if (!stop_ok) begin
      model_err();
      return;
    end
    if (m_buf.size() == 0) begin
      if (b == 8'hA5) m_buf.push_back(b);
      return;
    end
    m_buf.push_back(b);
    if (m_buf.size() == PKT_LEN) begin
      ok = 1'b1;
`ifdef UART_CHECKSUM_EN
      ok = (m_buf[4] == (m_buf[1] ^ m_buf[2] ^ m_buf[3]));
`endif
      if (ok) begin
        m_x   = int'(m_buf[3][7:6]) * 256 + int'(m_buf[1]);
        m_y   = int'(m_buf[3][5:4]) * 256 + int'(m_buf[2]);
        m_dir = int'(m_buf[3][3:2]);
        m_commits++;
        m_buf.delete();
      end else begin
        model_err();
      end
    end
  endfunction

  function automatic void model_idle(input int bits);
    if (bits >= int'(TIMEOUT_BITS) && m_buf.size() > 0) model_err();
  endfunction

  // Per-cycle comparison against the model, sampled on the falling edge.
  task automatic compare_cycle();
    if (!chk_en) return;
    check("fv_consecutive", {31'b0, frame_valid & fv_prev}, 0);
    fv_prev = frame_valid;
    if (settle) begin
      if (frame_valid) fv_total++;
    end else begin
      check("xpos", 32'(xpos_op), m_x);
      check("ypos", 32'(ypos_op), m_y);
      check("dir", 32'(direction_op), m_dir);
      check("err", 32'(err_count), m_err);
      check("fv_idle", 32'(frame_valid), 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) step();
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    int f0, c0;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    settle = 1'b1;
    f0 = fv_total;
    drive_bit(stop_ok);
    rx = 1'b1;
    c0 = m_commits;
    model_byte(b, stop_ok);
    check("fv_pulses", fv_total - f0, m_commits - c0);
    settle = 1'b0;
    drive_bit(1'b1);  // one idle bit between bytes
  endtask

  task automatic send_pkt(input logic [7:0] xl, input logic [7:0] yl, input logic [7:0] hi);
    send_byte(8'hA5, 1'b1);
    send_byte(xl, 1'b1);
    send_byte(yl, 1'b1);
    send_byte(hi, 1'b1);
`ifdef UART_CHECKSUM_EN
    send_byte(xl ^ yl ^ hi, 1'b1);
`endif
  endtask

  task automatic idle_bits(input int bits);
    settle = 1'b1;
    rx = 1'b1;
    wait_clks(bits * BIT_CLKS);
    model_idle(bits);
    settle = 1'b0;
  endtask

  task automatic expect_out(input string name, input int x, input int y, input int d,
                            input int e);
    check({name, "_x"}, 32'(xpos_op), x);
    check({name, "_y"}, 32'(ypos_op), y);
    check({name, "_dir"}, 32'(direction_op), d);
    check({name, "_err"}, 32'(err_count), e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_commits = 0;
    model_reset();
    rx  = 1'b1;
    rst = 1'b1;
    wait_clks(4);
    chk_en = 1'b1;
    wait_clks(2);
    expect_out("reset", 300, 2, 0, 0);
    check("reset_fv", 32'(frame_valid), 0);
    rst = 1'b0;
    wait_clks(BIT_CLKS);

    // Basic packet: X = 0x12C, Y = 0x064, dir = 2.
    send_pkt(8'h2C, 8'h64, 8'h48);
    check("model_y_pin", m_y, 100);
    check("commits_a", m_commits, 1);
    expect_out("pkt_a", 300, 100, 2, 0);

    // Garbage, then X = 0x27F, Y = 0x303, dir = 1.
    send_byte(8'h13, 1'b1);
    send_byte(8'h37, 1'b1);
    send_pkt(8'h7F, 8'h03, 8'hB4);
    check("model_x_pin", m_x, 639);
    expect_out("garbage", 639, 771, 1, 0);

    // Framing error on byte2; rest of that packet is then just noise.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h2C, 1'b1);
    send_byte(8'h64, 1'b0);
    send_byte(8'h48, 1'b1);
`ifdef UART_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    expect_out("frame_err", 639, 771, 1, 1);
    send_pkt(8'h2C, 8'h64, 8'h48);
    expect_out("after_ferr", 300, 100, 2, 1);

    // Timeout after byte1.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    idle_bits(25);
    expect_out("timeout", 300, 100, 2, 2);

    // A5 as payload is plain data: X = 0x1A5, Y = 0x10F, dir = 3.
    send_pkt(8'hA5, 8'h0F, 8'h5C);
    expect_out("a5_payload", 421, 271, 3, 2);

    // Short glitch: no byte, no error.
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    expect_out("glitch", 421, 271, 3, 2);

`ifdef UART_CHECKSUM_EN
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hFF, 1'b1);
    expect_out("bad_chk", 421, 271, 3, 3);
`endif

    // Reset mid-packet.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h2C, 1'b1);
    settle = 1'b1;
    rst = 1'b1;
    wait_clks(3);
    model_reset();
    expect_out("mid_rst", 300, 2, 0, 0);
    rst = 1'b0;
    wait_clks(2);
    settle = 1'b0;
    wait_clks(BIT_CLKS);
    send_pkt(8'h7F, 8'h03, 8'hB4);
    expect_out("after_rst", 639, 771, 1, 0);

    check("fv_total", fv_total, m_commits);
    wait_clks(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
